// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: source 0 has strict priority, sources 1/2
// round-robin between themselves, with a starvation override that beats source 0.
module rf_wb_arbiter #(
  parameter int DW           = 32,
  parameter int AW           = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          req2_valid,
  input  logic [AW-1:0] req2_addr,
  input  logic [DW-1:0] req2_data,
  output logic          req2_ready,
  output logic          rf_wr,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_data,
  output logic [1:0]    grant_id
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SRC0     = 2'd0,
    SRC1     = 2'd1,
    SRC2     = 2'd2,
    SRC_NONE = 2'd3
  } src_e;

  // rr_prefer_2 == 0 means source 1 wins a 1-vs-2 tie
  logic          rr_prefer_2;
  logic [3:0]    starve_1;
  logic [3:0]    starve_2;
  logic          force_1;
  logic          force_2;
  src_e          grant;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  assign force_1 = req1_valid && (starve_1 == STARVE_MAX);
  assign force_2 = req2_valid && (starve_2 == STARVE_MAX);

  always_comb begin
    grant = SRC_NONE;
    if (reset) begin
      if (force_1 && force_2)
        grant = rr_prefer_2 ? SRC2 : SRC1;
      else if (force_1)
        grant = SRC1;
      else if (force_2)
        grant = SRC2;
      else if (req0_valid)
        grant = SRC0;
      else if (req1_valid && req2_valid)
        grant = rr_prefer_2 ? SRC2 : SRC1;
      else if (req1_valid)
        grant = SRC1;
      else if (req2_valid)
        grant = SRC2;
    end
  end

  assign req0_ready = (grant == SRC0);
  assign req1_ready = (grant == SRC1);
  assign req2_ready = (grant == SRC2);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    case (grant)
      SRC0: begin
        sel_addr = req0_addr;
        sel_data = req0_data;
      end
      SRC1: begin
        sel_addr = req1_addr;
        sel_data = req1_data;
      end
      SRC2: begin
        sel_addr = req2_addr;
        sel_data = req2_data;
      end
      default: begin
        sel_addr = '0;
        sel_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_wr    <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
      grant_id <= 2'b11;
    end else if (grant != SRC_NONE) begin
      // register 0 is hardwired: accept the request but suppress the write
      rf_wr    <= (sel_addr != '0);
      rf_addr  <= sel_addr;
      rf_data  <= sel_data;
      grant_id <= grant;
    end else begin
      rf_wr    <= 1'b0;
      grant_id <= 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      rr_prefer_2 <= 1'b0;
    else if (grant == SRC1)
      rr_prefer_2 <= 1'b1;
    else if (grant == SRC2)
      rr_prefer_2 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_1 <= '0;
      starve_2 <= '0;
    end else begin
      if (!req1_valid || grant == SRC1)
        starve_1 <= '0;
      else if (starve_1 != STARVE_MAX)
        starve_1 <= starve_1 + 4'd1;

      if (!req2_valid || grant == SRC2)
        starve_2 <= '0;
      else if (starve_2 != STARVE_MAX)
        starve_2 <= starve_2 + 4'd1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: stimulus pushes expected writes into a
// scoreboard queue, a monitor pops and compares each presented grant.
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [1:0]    gid;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid, req2_valid;
  logic [AW-1:0] req0_addr, req1_addr, req2_addr;
  logic [DW-1:0] req0_data, req1_data, req2_data;
  logic          req0_ready, req1_ready, req2_ready;
  logic          rf_wr;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [1:0]    grant_id;

  int n_cmp = 0;
  int n_bad = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DW(DW), .AW(AW), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .req2_valid(req2_valid), .req2_addr(req2_addr), .req2_data(req2_data), .req2_ready(req2_ready),
    .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data), .grant_id(grant_id)
  );

  // one cycle of stimulus: drive at negedge, check readys, queue expected writes
  task automatic cyc(input logic rst, input logic [2:0] v,
                     input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                     input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                     input logic [2:0] er, input string nm);
    logic [2:0] rdy;
    wr_t e;
    @(negedge clk);
    reset = rst;
    req0_valid = v[0]; req0_addr = a0; req0_data = d0;
    req1_valid = v[1]; req1_addr = a1; req1_data = d1;
    req2_valid = v[2]; req2_addr = a2; req2_data = d2;
    #1;
    rdy = {req2_ready, req1_ready, req0_ready};
    n_cmp++;
    if (rdy !== er) begin
      n_bad++;
      $display("FAIL %s readys: got %b expected %b", nm, rdy, er);
    end
    if (er[0]) begin e.gid = 2'd0; e.wr = (a0 != 0); e.addr = a0; e.data = d0; exp_q.push_back(e); end
    if (er[1]) begin e.gid = 2'd1; e.wr = (a1 != 0); e.addr = a1; e.data = d1; exp_q.push_back(e); end
    if (er[2]) begin e.gid = 2'd2; e.wr = (a2 != 0); e.addr = a2; e.data = d2; exp_q.push_back(e); end
  endtask

  task automatic idle(input string nm);
    cyc(1'b1, 3'b000, '0, '0, '0, '0, '0, '0, 3'b000, nm);
  endtask

  task automatic chk_out(input logic wr, input logic [1:0] gid,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input string nm);
    n_cmp++;
    if (rf_wr !== wr || grant_id !== gid || rf_addr !== a || rf_data !== d) begin
      n_bad++;
      $display("FAIL %s outputs: got wr=%b gid=%0d addr=%0d data=%h expected wr=%b gid=%0d addr=%0d data=%h",
               nm, rf_wr, grant_id, rf_addr, rf_data, wr, gid, a, d);
    end
  endtask

  // monitor: every presented grant must match the head of the scoreboard
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (grant_id !== 2'b11) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got gid=%0d addr=%0d data=%h expected none",
                   grant_id, rf_addr, rf_data);
        end else begin
          e = exp_q.pop_front();
          if (rf_wr !== e.wr || grant_id !== e.gid || rf_addr !== e.addr || rf_data !== e.data) begin
            n_bad++;
            $display("FAIL write: got wr=%b gid=%0d addr=%0d data=%h expected wr=%b gid=%0d addr=%0d data=%h",
                     rf_wr, grant_id, rf_addr, rf_data, e.wr, e.gid, e.addr, e.data);
          end
        end
      end else begin
        n_cmp++;
        if (rf_wr !== 1'b0) begin
          n_bad++;
          $display("FAIL idle_wr: got rf_wr=%b expected 0", rf_wr);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    req0_valid = 0; req1_valid = 0; req2_valid = 0;
    req0_addr = '0; req1_addr = '0; req2_addr = '0;
    req0_data = '0; req1_data = '0; req2_data = '0;

    // reset held 2 cycles with every source requesting
    cyc(1'b0, 3'b111, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h3, 3'b000, "reset_a");
    cyc(1'b0, 3'b111, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h3, 3'b000, "reset_b");
    chk_out(1'b0, 2'b11, '0, '0, "reset_state");

    // solo source 1, then idle: address must hold
    cyc(1'b1, 3'b010, '0, '0, 5'd5, 32'hDEADBEEF, '0, '0, 3'b010, "solo1");
    idle("solo1_idle_a");
    idle("solo1_idle_b");
    chk_out(1'b0, 2'b11, 5'd5, 32'hDEADBEEF, "solo1_hold");

    // round robin 1/2 after reset (source 1 first)
    cyc(1'b0, 3'b000, '0, '0, '0, '0, '0, '0, 3'b000, "rr_reset");
    cyc(1'b1, 3'b110, '0, '0, 5'd1, 32'h11, 5'd2, 32'h22, 3'b010, "rr_1");
    cyc(1'b1, 3'b110, '0, '0, 5'd3, 32'h33, 5'd2, 32'h22, 3'b100, "rr_2");
    cyc(1'b1, 3'b110, '0, '0, 5'd3, 32'h33, 5'd4, 32'h44, 3'b010, "rr_3");
    cyc(1'b1, 3'b110, '0, '0, 5'd5, 32'h55, 5'd4, 32'h44, 3'b100, "rr_4");
    idle("rr_idle");

    // starvation: source 0 wins 8 cycles, source 1 forced on the 9th
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, 3'b011, 5'd7, 32'h700 + i, 5'd9, 32'h99, '0, '0, 3'b001, "starve_p0");
    cyc(1'b1, 3'b011, 5'd7, 32'h709, 5'd9, 32'h99, '0, '0, 3'b010, "starve_force");
    cyc(1'b1, 3'b011, 5'd7, 32'h709, 5'd10, 32'hAA, '0, '0, 3'b001, "starve_back0");
    cyc(1'b1, 3'b011, 5'd7, 32'h70A, 5'd10, 32'hAA, '0, '0, 3'b001, "starve_cleared");
    idle("starve_idle");

    // address 0 accepted but not written
    cyc(1'b1, 3'b001, 5'd0, 32'h1234, '0, '0, '0, '0, 3'b001, "addr0");
    idle("addr0_idle");

    // reset mid-stream
    cyc(1'b1, 3'b100, '0, '0, '0, '0, 5'd3, 32'h333, 3'b100, "mid_grant2");
    cyc(1'b0, 3'b110, '0, '0, 5'd6, 32'h666, 5'd4, 32'h444, 3'b000, "mid_reset");
    cyc(1'b1, 3'b110, '0, '0, 5'd6, 32'h666, 5'd4, 32'h444, 3'b010, "mid_after1");
    chk_out(1'b0, 2'b11, '0, '0, "mid_reset_cleared");
    cyc(1'b1, 3'b100, '0, '0, '0, '0, 5'd4, 32'h444, 3'b100, "mid_after2");
    idle("end_a");
    idle("end_b");
    idle("end_c");

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
